// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text writer.
package text_pkg;

  localparam int unsigned COLS = 70;
  localparam int unsigned ROWS = 30;

  localparam logic [7:0] CHAR_NEWLINE = 8'hA9;
  localparam logic [7:0] CHAR_BS      = 8'h08;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  typedef enum logic [1:0] {
    StClrAll,
    StIdle,
    StClrRow
  } state_e;

endpackage

// File: rtl/text_writer.sv
// Turns a stream of ASCII codes into character-memory writes and tracks the text cursor.
// Clears the whole screen after reset and a single row whenever the cursor wraps to row 0.
module text_writer #(
  parameter int unsigned COLS = text_pkg::COLS,
  parameter int unsigned ROWS = text_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ascii_valid,
  input  logic [7:0]  ascii_code,
  output logic        ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);
  import text_pkg::*;

  localparam logic [11:0] ColsW    = 12'(COLS);
  localparam logic [11:0] LastCell = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LastRowCell = 12'(COLS - 1);
  localparam logic [4:0]  LastRow  = 5'(ROWS - 1);
  localparam logic [6:0]  LastCol  = 7'(COLS - 1);

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [11:0] cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        accept;
  logic        is_print;
  logic        adv_row;
  logic [11:0] row_base;

  assign ready    = (state_q == StIdle);
  assign accept   = ascii_valid && ready;
  assign is_print = (ascii_code >= 8'h20) && (ascii_code <= 8'h7E);
  assign row_base = 12'(row_q) * ColsW;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    adv_row   = 1'b0;

    unique case (state_q)
      StClrAll: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = CHAR_SPACE;
        if (cnt_q == LastCell) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      StClrRow: begin
        // row_q already holds the freshly wrapped row
        wr_en_d   = 1'b1;
        wr_addr_d = row_base + cnt_q;
        wr_data_d = CHAR_SPACE;
        if (cnt_q == LastRowCell) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end

      StIdle: begin
        if (accept) begin
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base + 12'(col_q);
            wr_data_d = ascii_code;
            if (col_q == LastCol) begin
              col_d   = '0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (ascii_code == CHAR_NEWLINE) begin
            col_d   = '0;
            adv_row = 1'b1;
          end else if (ascii_code == CHAR_BS && !(row_q == '0 && col_q == '0)) begin
            if (col_q == '0) begin
              col_d = LastCol;
              row_d = row_q - 5'd1;
            end else begin
              col_d = col_q - 7'd1;
            end
            wr_en_d   = 1'b1;
            wr_addr_d = 12'(row_d) * ColsW + 12'(col_d);
            wr_data_d = CHAR_SPACE;
          end
        end
      end

      default: state_d = StClrAll;
    endcase

    if (adv_row) begin
      if (row_q == LastRow) begin
        row_d   = '0;
        cnt_d   = '0;
        state_d = StClrRow;
      end else begin
        row_d = row_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClrAll;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_text_writer.sv
// Randomised and directed bench for text_writer against a queue-based screen model.
module tb_text_writer;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ascii_valid = 1'b0;
  logic [7:0]  ascii_code = 8'h00;
  logic        ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  always #5 clk = ~clk;

  text_writer #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ascii_valid(ascii_valid),
    .ascii_code (ascii_code),
    .ready      (ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: pending clear writes are a queue of addresses; cursor is plain ints.
  int q[$];
  int m_row = 0;
  int m_col = 0;
  bit m_known = 1'b0;
  bit e_wr = 1'b0;
  bit e_ad = 1'b0;
  bit e_ready = 1'b0;
  int e_addr = 0;
  int e_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_row();
    m_row++;
    if (m_row == ROWS) begin
      m_row = 0;
      for (int i = 0; i < COLS; i++) q.push_back(i);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] c);
    if (r) begin
      q.delete();
      for (int i = 0; i < CELLS; i++) q.push_back(i);
      m_row = 0; m_col = 0;
      e_wr = 0; e_ad = 1; e_addr = 0; e_data = 0;
      m_known = 1;
    end else if (m_known && q.size() != 0) begin
      e_wr = 1; e_ad = 1; e_addr = q.pop_front(); e_data = 32'h20;
    end else if (m_known) begin
      e_wr = 0; e_ad = 0;
      if (v) begin
        if (c >= 8'h20 && c <= 8'h7E) begin
          e_wr = 1; e_ad = 1; e_addr = m_row * COLS + m_col; e_data = int'(c);
          m_col++;
          if (m_col == COLS) begin
            m_col = 0;
            next_row();
          end
        end else if (c == 8'hA9) begin
          m_col = 0;
          next_row();
        end else if (c == 8'h08 && (m_row != 0 || m_col != 0)) begin
          if (m_col == 0) begin
            m_col = COLS - 1;
            m_row--;
          end else begin
            m_col--;
          end
          e_wr = 1; e_ad = 1; e_addr = m_row * COLS + m_col; e_data = 32'h20;
        end
      end
    end
    e_ready = m_known && (q.size() == 0);
  endtask

  // Per-cycle compare, half a period after the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        if (e_ad) begin
          chk("wr_addr", 32'(wr_addr), e_addr);
          chk("wr_data", 32'(wr_data), e_data);
        end
        chk("ready", 32'(ready), 32'(e_ready));
        chk("cursor_row", 32'(cursor_row), m_row);
        chk("cursor_col", 32'(cursor_col), m_col);
      end
    end
  end

  task automatic cycle(input bit r, input bit v, input logic [7:0] c);
    @(negedge clk);
    #1;
    rst = r;
    ascii_valid = v;
    ascii_code = c;
    model_step(r, v, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input bit v, input logic [7:0] c, output int nwr);
    int n;
    n = 0;
    nwr = 0;
    while (q.size() != 0 && n < 3000) begin
      cycle(1'b0, v, c);
      settle();
      if (wr_en === 1'b1) nwr++;
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic reset_and_clear();
    int n;
    cycle(1'b1, 1'b0, 8'h00);
    settle();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    drain(1'b0, 8'h00, n);
    chk("clr_all_count", n, CELLS);
    chk("clr_all_last_addr", 32'(wr_addr), 32'd2099);
    chk("clr_all_ready", 32'(ready), 32'd1);
    chk("clr_all_cursor", {cursor_row, cursor_col}, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] c;
    bit r, v;
    int sel;

    cycle(1'b1, 1'b0, 8'h00);
    reset_and_clear();

    // 'A' at (0,0)
    cycle(1'b0, 1'b1, 8'h41);
    settle();
    chk("A_wr_en", 32'(wr_en), 32'd1);
    chk("A_addr", 32'(wr_addr), 32'd0);
    chk("A_data", 32'(wr_data), 32'h41);
    chk("A_col", 32'(cursor_col), 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    settle();
    chk("A_strobe_once", 32'(wr_en), 32'd0);

    // 71 printables from (0,0)
    reset_and_clear();
    for (int i = 0; i < 71; i++) begin
      c = 8'(8'h21 + (i % 94));
      cycle(1'b0, 1'b1, c);
    end
    settle();
    chk("p71_addr", 32'(wr_addr), 32'd70);
    chk("p71_row", 32'(cursor_row), 32'd1);
    chk("p71_col", 32'(cursor_col), 32'd1);

    // Backspace across the row boundary
    cycle(1'b0, 1'b1, 8'h08);
    cycle(1'b0, 1'b1, 8'h08);
    settle();
    chk("bs_addr", 32'(wr_addr), 32'd69);
    chk("bs_data", 32'(wr_data), 32'h20);
    chk("bs_cursor", {cursor_row, cursor_col}, {5'd0, 7'd69});
    reset_and_clear();
    cycle(1'b0, 1'b1, 8'h08);
    settle();
    chk("bs00_wr_en", 32'(wr_en), 32'd0);

    // Newline at (29,5) wraps and clears row 0; offered codes are dropped
    for (int i = 0; i < 29; i++) cycle(1'b0, 1'b1, 8'hA9);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h61);
    settle();
    chk("at_29_5", {cursor_row, cursor_col}, {5'd29, 7'd5});
    cycle(1'b0, 1'b1, 8'hA9);
    settle();
    chk("nl_wrap_cursor", {cursor_row, cursor_col}, 32'd0);
    chk("nl_wrap_ready", 32'(ready), 32'd0);
    chk("nl_wrap_wr_en", 32'(wr_en), 32'd0);
    drain(1'b1, 8'h5A, n);
    chk("clr_row_count", n, COLS);
    chk("clr_row_last", 32'(wr_addr), 32'd69);
    cycle(1'b0, 1'b0, 8'h00);
    settle();
    chk("dropped_wr_en", 32'(wr_en), 32'd0);
    chk("dropped_col", 32'(cursor_col), 32'd0);

    // Reset in the middle of a row clear
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 8'hA9);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    settle();
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    settle();
    chk("restart_wr_en", 32'(wr_en), 32'd1);
    chk("restart_addr", 32'(wr_addr), 32'd0);
    drain(1'b0, 8'h00, n);

    // Printable in the last cell wraps to row 0
    for (int i = 0; i < 29; i++) cycle(1'b0, 1'b1, 8'hA9);
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1, 8'h78);
    settle();
    chk("last_cell_addr", 32'(wr_addr), 32'd2099);
    chk("last_cell_ready", 32'(ready), 32'd0);
    drain(1'b0, 8'h00, n);
    chk("last_cell_clr", n, COLS);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      r = ($urandom_range(0, 1999) == 0);
      v = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      if (sel < 4) c = 8'($urandom_range(32, 126));
      else if (sel < 6) c = 8'hA9;
      else if (sel < 8) c = 8'h08;
      else if (sel == 8) c = 8'h00;
      else c = 8'($urandom_range(0, 255));
      cycle(r, v, c);
    end
    drain(1'b0, 8'h00, n);
    cycle(1'b0, 1'b0, 8'h00);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have parameter COLS, default 70, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows on screen (COLS*ROWS = 2100 cells).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port ascii_valid  input  1  ascii_code carries a character this cycle.
REQ-006 SHALL have port ascii_code  input  8  character from the key lookup stage.
REQ-007 SHALL have port ready  output  1  block accepts a character this cycle.
REQ-008 SHALL have port wr_en  output  1  write strobe to the character memory.
REQ-009 SHALL have port wr_addr  output  12  cell address, row*COLS+col.
REQ-010 SHALL have port wr_data  output  8  ASCII value written.
REQ-011 SHALL have port cursor_row  output  5  current cursor row.
REQ-012 SHALL have port cursor_col  output  7  current cursor column.

Function
REQ-013 SHALL accept a character only on a cycle with ascii_valid=1 and ready=1; ascii_valid while ready=0 is ignored and not queued.
REQ-014 SHALL ignore an accepted ascii_code of 8'h00 (no write, no cursor move).
REQ-015 SHALL, for an accepted printable code (8'h20-8'h7E), assert wr_en for exactly one cycle on the cycle after acceptance, with wr_addr = pre-advance cursor address and wr_data = code.
REQ-016 SHALL advance the cursor on the same edge that registers the write: col+1, or col=0 and row+1 when col = COLS-1.
REQ-017 SHALL, for newline 8'hA9, set col=0 and row+1 with no write.
REQ-018 SHALL, for backspace 8'h08, move the cursor back one cell (col-1, or col=COLS-1 and row-1 when col=0) and write 8'h20 at the new position; backspace at row 0 col 0 is a no-op.
REQ-019 SHALL ignore all other codes.
REQ-020 SHALL, when a row advance passes row ROWS-1, wrap to row 0 and enter CLR_ROW.
REQ-021 SHALL use states CLR_ALL, IDLE and CLR_ROW; ready=1 only in IDLE.
REQ-022 SHALL, in CLR_ROW, write 8'h20 to the COLS cells of the new cursor row, one per cycle in ascending address order, then return to IDLE; COLS cycles total, cursor fixed at col 0.
REQ-023 SHALL, in CLR_ALL, write 8'h20 to addresses 0..COLS*ROWS-1, one per cycle, then enter IDLE.
REQ-024 SHALL compute wr_addr at 12-bit width; no address above COLS*ROWS-1 is ever issued.

Reset
REQ-025 SHALL, on a clock edge with rst=1, set state=CLR_ALL, cursor_row=0, cursor_col=0, ready=0, wr_en=0, wr_addr=0, wr_data=0, and the clear counter to 0.
REQ-026 SHALL, on rst during CLR_ROW or CLR_ALL, abandon the clear and restart CLR_ALL from address 0.
REQ-027 SHALL, on rst in the same cycle as an accepted character, discard the character.

Structure
REQ-028 SHALL take COLS, ROWS, CHAR_NEWLINE=8'hA9, CHAR_BS=8'h08, CHAR_SPACE=8'h20 and the state enum from shared package text_pkg.
REQ-029 SHALL be one module with no sub-modules; the address multiply-add is inline.

Verification
REQ-030 SHALL cover: rst pulse -> 2100 consecutive wr_en cycles, addr 0..2099, data 8'h20, then ready=1 with cursor (0,0).
REQ-031 SHALL cover: 'A' (8'h41) at cursor (0,0) -> next cycle wr_en=1, addr=0, data=8'h41, and cursor becomes (0,1).
REQ-032 SHALL cover: 71 printable codes from (0,0) -> 71st write at addr 70, and cursor (1,1).
REQ-033 SHALL cover: 8'hA9 at (29,5) -> cursor (0,0), 70 writes of 8'h20 to addr 0..69, ready=0 throughout, and a code offered meanwhile is dropped.
REQ-034 SHALL cover: 8'h08 at (1,0) -> write 8'h20 at addr 69 and cursor (0,69); 8'h08 at (0,0) -> no write.
REQ-035 SHALL cover: rst asserted mid CLR_ROW -> next cycle wr_en=0, then CLR_ALL restarts at addr 0.
